// File: rtl/mmio_arbiter_if.sv
// Bundle of the two requester ports and the shared MMIO port of mmio_arbiter.
// slave: the arbiter's view. master: requesters plus register file (testbench side).
interface mmio_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_din;
  logic        m0_ack;
  logic [31:0] m0_dout;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_din;
  logic        m1_ack;
  logic [31:0] m1_dout;

  logic [31:0] mmio_addr;
  logic        mmio_we;
  logic [31:0] mmio_din;
  logic [31:0] mmio_dout;

  logic        busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_din,
    input  m1_req, m1_we, m1_addr, m1_din,
    input  mmio_dout,
    output m0_ack, m0_dout, m1_ack, m1_dout,
    output mmio_addr, mmio_we, mmio_din, busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_din,
    output m1_req, m1_we, m1_addr, m1_din,
    output mmio_dout,
    input  m0_ack, m0_dout, m1_ack, m1_dout,
    input  mmio_addr, mmio_we, mmio_din, busy
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-requester arbiter for a shared MMIO register file: IDLE -> ACCESS -> DONE per grant.
// Define MMIO_ARB_RR_EN for round-robin on simultaneous requests; otherwise m0 has fixed priority.
module mmio_arbiter (
  input  logic          clk,
  input  logic          rst,
  mmio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] m0_dout_q, m0_dout_d;
  logic [31:0] m1_dout_q, m1_dout_d;
  logic        any_req;
  logic        grant_m1;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef MMIO_ARB_RR_EN
  // rr_q set means m0 was granted last, so m1 wins the next tie.
  logic rr_q, rr_d;

  assign grant_m1 = bus.m1_req & (~bus.m0_req | rr_q);

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) rr_d = ~grant_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign grant_m1 = bus.m1_req & ~bus.m0_req;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          owner_d = grant_m1;
          we_d    = grant_m1 ? bus.m1_we   : bus.m0_we;
          addr_d  = grant_m1 ? bus.m1_addr : bus.m0_addr;
          din_d   = grant_m1 ? bus.m1_din  : bus.m0_din;
        end
      end
      ACCESS: begin
        state_d = DONE;
        // Read data is combinational from the register file, so it is valid during ACCESS.
        if (!we_q) begin
          if (owner_q) m1_dout_d = bus.mmio_dout;
          else         m0_dout_d = bus.mmio_dout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
    end
  end

  // The shared bus is driven only during ACCESS so a stale write can never leak out.
  assign bus.mmio_addr = (state_q == ACCESS) ? addr_q : '0;
  assign bus.mmio_we   = (state_q == ACCESS) & we_q;
  assign bus.mmio_din  = (state_q == ACCESS) ? din_q  : '0;

  assign bus.m0_ack  = (state_q == DONE) & ~owner_q;
  assign bus.m1_ack  = (state_q == DONE) &  owner_q;
  assign bus.m0_dout = m0_dout_q;
  assign bus.m1_dout = m1_dout_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed testbench for mmio_arbiter; expected values are hand-computed from the cycle timing.
// Works with or without MMIO_ARB_RR_EN defined.
module tb_mmio_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mmio_arbiter_if bus ();

  mmio_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs and checks both happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_m0_ack"},   bus.m0_ack,    32'd0);
    check({tag, "_m1_ack"},   bus.m1_ack,    32'd0);
    check({tag, "_mmio_we"},  bus.mmio_we,   32'd0);
    check({tag, "_mmio_adr"}, bus.mmio_addr, 32'd0);
    check({tag, "_mmio_din"}, bus.mmio_din,  32'd0);
    check({tag, "_busy"},     bus.busy,      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp_we;
    logic [6:0] exp_ack;
    logic [6:0] exp_busy;
    int         exp_owner [4];

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_din = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_din = '0;
    bus.mmio_dout = 32'h0;

    // Reset state
    step();
    step();
    check_idle_zero("rst");
    check("rst_m0_dout", bus.m0_dout, 32'd0);
    check("rst_m1_dout", bus.m1_dout, 32'd0);
    rst = 1'b0;

    // m0 write: access in N+1, ack in N+2
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0000_7f08; bus.m0_din = 32'h1234_5678;
    check("wr_n_we", bus.mmio_we, 32'd0);
    step();
    check("wr_acc_we",   bus.mmio_we,   32'd1);
    check("wr_acc_addr", bus.mmio_addr, 32'h0000_7f08);
    check("wr_acc_din",  bus.mmio_din,  32'h1234_5678);
    check("wr_acc_busy", bus.busy,      32'd1);
    check("wr_acc_ack",  bus.m0_ack,    32'd0);
    step();
    check("wr_done_ack0", bus.m0_ack,  32'd1);
    check("wr_done_ack1", bus.m1_ack,  32'd0);
    check("wr_done_we",   bus.mmio_we, 32'd0);
    check("wr_done_busy", bus.busy,    32'd1);
    step();
    bus.m0_req = 1'b0;
    check_idle_zero("wr_idle");

    // m1 read with combinational register-file data
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h0000_7f04; bus.m1_din = 32'h0;
    bus.mmio_dout = 32'hCAFE_0001;
    step();
    check("rd_acc_addr", bus.mmio_addr, 32'h0000_7f04);
    check("rd_acc_we",   bus.mmio_we,   32'd0);
    step();
    check("rd_done_ack1", bus.m1_ack,  32'd1);
    check("rd_done_ack0", bus.m0_ack,  32'd0);
    check("rd_dout1",     bus.m1_dout, 32'hCAFE_0001);
    check("rd_dout0",     bus.m0_dout, 32'd0);
    step();
    bus.m1_req = 1'b0;
    bus.mmio_dout = 32'h0BAD_0BAD;
    step();
    check("rd_hold_dout1", bus.m1_dout, 32'hCAFE_0001);
    check("rd_hold_busy",  bus.busy,    32'd0);

    // m0 write with req held past ack: a fresh access after one IDLE cycle
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0000_7f10; bus.m0_din = 32'hAAAA_5555;
    exp_we   = 7'b0001001;  // bit i = cycle i+1 after the request
    exp_ack  = 7'b0010010;
    exp_busy = 7'b0011011;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("hold_we_%0d", i),   bus.mmio_we, {31'd0, exp_we[i]});
      check($sformatf("hold_ack_%0d", i),  bus.m0_ack,  {31'd0, exp_ack[i]});
      check($sformatf("hold_busy_%0d", i), bus.busy,    {31'd0, exp_busy[i]});
      if (i == 4) bus.m0_req = 1'b0;
    end
    check("hold_dout0", bus.m0_dout, 32'd0);

    // Both requesting continuously, starting from a reset pointer
    rst = 1'b1;
    step();
    check_idle_zero("rst2");
    check("rst2_m1_dout", bus.m1_dout, 32'd0);
    rst = 1'b0;
`ifdef MMIO_ARB_RR_EN
    exp_owner = '{0, 1, 0, 1};
`else
    exp_owner = '{0, 0, 0, 0};
`endif
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0000_7f00;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h0000_7f00;
    for (int k = 0; k < 4; k++) begin
      bus.mmio_dout = 32'h0000_0100 + k;
      step();
      check($sformatf("arb_acc_busy_%0d", k), bus.busy,      32'd1);
      check($sformatf("arb_acc_addr_%0d", k), bus.mmio_addr, 32'h0000_7f00);
      check($sformatf("arb_acc_we_%0d", k),   bus.mmio_we,   32'd0);
      step();
      check($sformatf("arb_ack0_%0d", k), bus.m0_ack, (exp_owner[k] == 0) ? 32'd1 : 32'd0);
      check($sformatf("arb_ack1_%0d", k), bus.m1_ack, (exp_owner[k] == 1) ? 32'd1 : 32'd0);
      check($sformatf("arb_dout_%0d", k),
            (exp_owner[k] == 0) ? bus.m0_dout : bus.m1_dout, 32'h0000_0100 + k);
      step();
      check($sformatf("arb_idle_busy_%0d", k), bus.busy, 32'd0);
    end
`ifndef MMIO_ARB_RR_EN
    check("arb_m1_never", bus.m1_dout, 32'd0);
`endif
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;

    // Reset during an m1 write access aborts it; held req is re-granted afterwards
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h0000_7f0c; bus.m1_din = 32'h0000_0055;
    step();
    check("abort_acc_we",   bus.mmio_we,   32'd1);
    check("abort_acc_addr", bus.mmio_addr, 32'h0000_7f0c);
    rst = 1'b1;
    step();
    check_idle_zero("abort");
    check("abort_m0_dout", bus.m0_dout, 32'd0);
    check("abort_m1_dout", bus.m1_dout, 32'd0);
    step();
    check_idle_zero("abort2");
    rst = 1'b0;
    step();
    check("retry_acc_we",   bus.mmio_we,   32'd1);
    check("retry_acc_addr", bus.mmio_addr, 32'h0000_7f0c);
    check("retry_acc_din",  bus.mmio_din,  32'h0000_0055);
    step();
    check("retry_ack1", bus.m1_ack, 32'd1);
    check("retry_ack0", bus.m0_ack, 32'd0);
    step();
    bus.m1_req = 1'b0;
    step();
    check_idle_zero("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 The block SHALL use clock clk (input, 1, rising-edge) and reset rst (input, 1, synchronous, active-high).
REQ-002 m0_req  input  1  CPU-side access request, held high until m0_ack.
REQ-003 m0_we  input  1  CPU-side write (1) / read (0), valid while m0_req high.
REQ-004 m0_addr  input  32  CPU-side byte address; m0_din  input  32  CPU-side write data.
REQ-005 m0_ack  output  1  one-cycle completion pulse to CPU; m0_dout  output  32  CPU-side read data, valid when m0_ack high.
REQ-006 m1_req, m1_we, m1_addr[31:0], m1_din[31:0], m1_ack, m1_dout[31:0] SHALL mirror REQ-002..005 for the PDU/debug requester.
REQ-007 mmio_addr  output  32  shared MMIO address; mmio_we  output  1  shared write enable; mmio_din  output  32  shared write data; mmio_dout  input  32  read data returned combinationally by the MMIO register file.
REQ-008 busy  output  1  high in any state other than IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any req high, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-010 In IDLE the block SHALL select one requester, latch its we/addr/din and its index into owner registers at the IDLE->ACCESS edge.
REQ-011 In ACCESS only, mmio_addr/mmio_we/mmio_din SHALL be driven from the latched values; otherwise all three SHALL be 0.
REQ-012 mmio_we SHALL be high for exactly one cycle per granted write and never for reads.
REQ-013 At the ACCESS->DONE edge, mmio_dout SHALL be captured into the owner's dout register for reads; for writes that dout register SHALL hold its previous value.
REQ-014 In DONE, only the owner's ack SHALL be high; the other ack SHALL stay 0.
REQ-015 Latency: req sampled high in IDLE at cycle N -> mmio access in cycle N+1 -> ack high in cycle N+2; throughput at most one access per 3 cycles.
REQ-016 Requests SHALL only be sampled in IDLE; req changes during ACCESS/DONE SHALL be ignored.
REQ-017 A requester SHALL drop req in the cycle after its ack; a req still high in IDLE after that SHALL be treated as a new access.
REQ-018 Both req high in IDLE SHALL resolve per REQ-024/REQ-025; the losing request SHALL remain pending and be granted on the next IDLE.
REQ-019 m0_dout/m1_dout SHALL hold their last captured values between accesses.

Reset
REQ-020 rst high SHALL force state IDLE, owner 0, latched addr/we/din 0, round-robin pointer 0 (favouring m0 next).
REQ-021 During and after reset: m0_ack=m1_ack=0, m0_dout=m1_dout=0, mmio_addr=0, mmio_we=0, mmio_din=0, busy=0.
REQ-022 Reset asserted in ACCESS or DONE SHALL abort the access: no ack issued, no mmio_we in the following cycle, dout unchanged other than cleared to 0.
REQ-023 After rst deasserts, a held req SHALL be granted as a fresh request from IDLE.

Configuration
REQ-024 With macro MMIO_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted most recently wins; pointer updates on every IDLE->ACCESS.
REQ-025 Without MMIO_ARB_RR_EN, m0 SHALL always win simultaneous requests (fixed priority); no pointer register SHALL exist.

Verification
REQ-026 m0 write addr 0x0000_7f08 din 0x1234_5678 at cycle N -> mmio_we=1, mmio_addr=0x7f08, mmio_din=0x12345678 in N+1 only; m0_ack=1 in N+2.
REQ-027 m1 read addr 0x0000_7f04 with mmio_dout=0xCAFE_0001 in access cycle -> m1_dout=0xCAFE0001 and m1_ack=1 two cycles after request; m0_ack stays 0.
REQ-028 m0 and m1 both request continuously (reads of 0x7f00) -> fixed priority: m0 every grant; with MMIO_ARB_RR_EN: grants alternate m0,m1,m0,m1, one ack every 3 cycles.
REQ-029 rst pulsed during ACCESS of an m1 write to 0x7f0c -> no m1_ack, mmio_we=0 next cycle, all outputs 0, busy=0.
REQ-030 m0 write then m0 holds req through ack and beyond -> second access starts in IDLE cycle after DONE, mmio_we again exactly one cycle.
